// File: rtl/pixel_plot_if.sv
// pixel_plot_if: request/plot bundle between drawing engines, pixel_plot_fifo and the VGA adapter.
interface pixel_plot_if #(parameter int DEPTH = 8);
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_x;
  logic [6:0]               in_y;
  logic [2:0]               in_colour;
  logic                     out_ready;
  logic [7:0]               vga_x;
  logic [6:0]               vga_y;
  logic [2:0]               vga_colour;
  logic                     vga_plot;
  logic [$clog2(DEPTH):0]   count;
  logic [15:0]              dropped;
  modport master (
    output in_valid, in_x, in_y, in_colour, out_ready,
    input  in_ready, vga_x, vga_y, vga_colour, vga_plot, count, dropped
  );
  modport slave (
    input  in_valid, in_x, in_y, in_colour, out_ready,
    output in_ready, vga_x, vga_y, vga_colour, vga_plot, count, dropped
  );
endinterface

// File: rtl/pixel_plot_fifo.sv
// pixel_plot_fifo: buffers pixel-plot requests and drains one registered pixel per clock to the VGA adapter.
// Off-screen clipping and the dropped counter are built only when PIXEL_PLOT_CLIP_EN is defined.
module pixel_plot_fifo #(
  parameter int DEPTH = 8,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input logic        clk,
  input logic        rst,
  pixel_plot_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic [17:0]   mem_q [DEPTH];
  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;
  logic          plot_q;
  logic          full, empty, push, wr_en, pop, clip;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  // Ready looks only at registered occupancy, so a pop never frees a slot on the same edge.
  assign bus.in_ready = !full && !rst;
  assign push  = bus.in_valid && bus.in_ready;
  assign wr_en = push && !clip;
  assign pop   = bus.out_ready && !empty;
`ifdef PIXEL_PLOT_CLIP_EN
  logic [15:0] dropped_q;
  assign clip = bus.in_x > 8'(X_MAX) || bus.in_y > 7'(Y_MAX);
  always_ff @(posedge clk)
    if (rst) dropped_q <= '0;
    else if (push && clip && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
  assign bus.dropped = dropped_q;
`else
  logic unused_params;
  assign unused_params = ^{X_MAX[0], Y_MAX[0]};
  assign clip = 1'b0;
  assign bus.dropped = '0;
`endif
  always_comb count_d = wr_en == pop ? count_q : wr_en ? count_q + 1'b1 : count_q - 1'b1;
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= {bus.in_x, bus.in_y, bus.in_colour};
  always_ff @(posedge clk)
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      plot_q  <= pop;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q <= rd_q + 1'b1;
        {x_q, y_q, colour_q} <= mem_q[rd_q];
      end
    end
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;
  assign bus.count      = count_q;
endmodule
